// File: rtl/alu_issue.sv
// alu_issue: single-issue stage feeding an external ALU with register file, writeback and Z/N/C flags
module alu_issue #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 5,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [RA_W-1:0]   instr_rd,
  input  logic [RA_W-1:0]   instr_rs1,
  input  logic [RA_W-1:0]   instr_rs2,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a1,
  output logic [DATA_W-1:0] alu_a2,
  output logic [OP_W-1:0]   alu_control,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_o,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  input  logic [RA_W-1:0]   dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);
  typedef enum logic [1:0] {IDLE, SETUP, FIRE, CAPTURE} state_t;
  state_t state, state_nx;
  logic [2**RA_W-1:0][DATA_W-1:0] rf;
  logic [RA_W-1:0] rd_q;
  logic [DATA_W:0] sum;
  logic accept, c_nx;
  assign instr_ready = state == IDLE;
  assign dbg_rdata = rf[dbg_raddr];
  always_comb begin
    accept = instr_valid & instr_ready;
    state_nx = state == IDLE ? (accept ? SETUP : IDLE) :
               state == SETUP ? FIRE :
               state == FIRE ? CAPTURE : IDLE;
    sum = {1'b0, alu_a1} + {1'b0, alu_a2};
    c_nx = alu_control == OP_W'(0) ? sum[DATA_W] :
           alu_control == OP_W'(1) ? (alu_a1 < alu_a2) : flag_c;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // r0 is never written, so it reads as zero without a read-side mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf <= '0;
      rd_q <= '0;
      alu_a1 <= '0;
      alu_a2 <= '0;
      alu_control <= '0;
      alu_enable <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      alu_enable <= state == SETUP;
      wb_valid <= state == CAPTURE;
      if (accept) begin
        alu_a1 <= rf[instr_rs1];
        alu_a2 <= instr_use_imm ? instr_imm : rf[instr_rs2];
        alu_control <= instr_op;
        rd_q <= instr_rd;
      end
      if (state == CAPTURE) begin
        if (rd_q != '0) rf[rd_q] <= alu_o;
        wb_rd <= rd_q;
        wb_data <= alu_o;
        flag_z <= alu_o == '0;
        flag_n <= alu_o[DATA_W-1];
        flag_c <= c_nx;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized self-checking bench with an ALU stub and a register-level reference model
module tb_alu_issue;
  logic clk = 0, reset = 1;
  logic instr_valid = 0, instr_ready, instr_use_imm = 0;
  logic [4:0] instr_op = 0, alu_control;
  logic [2:0] instr_rd = 0, instr_rs1 = 0, instr_rs2 = 0, wb_rd, dbg_raddr = 0;
  logic [7:0] instr_imm = 0, alu_a1, alu_a2, alu_o = 0, wb_data, dbg_rdata;
  logic alu_enable, wb_valid, flag_z, flag_n, flag_c;
  int tests_run = 0, failed = 0;
  logic [7:0] mreg [8];
  logic m_z, m_n, m_c;
  logic [7:0] exp_res, obs_data;
  logic [2:0] obs_rd;
  logic [3:0] en_pat, wbv_pat, rdy_pat;

  alu_issue dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm), .alu_a1(alu_a1), .alu_a2(alu_a2),
    .alu_control(alu_control), .alu_enable(alu_enable), .alu_o(alu_o), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd11: return b;
      default: return ~a;
    endcase
  endfunction

  // external ALU stand-in: result updates on the rising edge of enable
  always @(posedge alu_enable) alu_o <= alu_f(alu_control, alu_a1, alu_a2);

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    m_z = 0; m_n = 0; m_c = 0;
  endtask

  task automatic model_step(input logic [4:0] op, input logic [2:0] rd, rs1, rs2, input logic ui, input logic [7:0] imm);
    int a, b;
    a = mreg[rs1];
    b = ui ? imm : mreg[rs2];
    exp_res = alu_f(op, 8'(a), 8'(b));
    if (rd != 0) mreg[rd] = exp_res;
    m_z = exp_res == 0;
    m_n = exp_res >= 128;
    if (op == 0) m_c = (a + b) > 255;
    if (op == 1) m_c = a < b;
  endtask

  // called at a negedge while idle; records what the stage shows on the four following negedges
  task automatic run_instr(input logic [4:0] op, input logic [2:0] rd, rs1, rs2, input logic ui, input logic [7:0] imm);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_use_imm = ui; instr_imm = imm;
    instr_valid = 1;
    model_step(op, rd, rs1, rs2, ui, imm);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) instr_valid = 0;
      en_pat[k] = alu_enable;
      wbv_pat[k] = wb_valid;
      rdy_pat[k] = instr_ready;
    end
    obs_rd = wb_rd;
    obs_data = wb_data;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    model_reset();
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = 3'(i); #1;
      tests_run++;
      if (dbg_rdata !== 8'h00) begin failed++; $display("FAIL reset_reg r%0d got %h want 00", i, dbg_rdata); end
    end
    tests_run++;
    if ({instr_ready, alu_enable, wb_valid, flag_z, flag_n, flag_c} !== 6'b100000) begin
      failed++; $display("FAIL reset_ctl got %b want 100000", {instr_ready, alu_enable, wb_valid, flag_z, flag_n, flag_c});
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_add_imm();
    run_instr(5'd11, 3'd1, 3'd0, 3'd0, 1, 8'h05);
    run_instr(5'd0, 3'd2, 3'd1, 3'd0, 1, 8'hFB);
    tests_run++;
    if (en_pat !== 4'b0010) begin failed++; $display("FAIL add_enable_timing got %b want 0010", en_pat); end
    tests_run++;
    if (wbv_pat !== 4'b1000) begin failed++; $display("FAIL add_wb_timing got %b want 1000", wbv_pat); end
    tests_run++;
    if (rdy_pat !== 4'b1000) begin failed++; $display("FAIL add_ready got %b want 1000", rdy_pat); end
    tests_run++;
    if ({obs_rd, obs_data} !== {3'd2, 8'h00}) begin failed++; $display("FAIL add_wb got rd%0d %h want rd2 00", obs_rd, obs_data); end
    tests_run++;
    if ({flag_z, flag_n, flag_c} !== 3'b101) begin failed++; $display("FAIL add_flags got %b want 101", {flag_z, flag_n, flag_c}); end
    dbg_raddr = 3'd2; #1;
    tests_run++;
    if (dbg_rdata !== 8'h00) begin failed++; $display("FAIL add_r2 got %h want 00", dbg_rdata); end
  endtask

  task automatic test_sub_flags();
    run_instr(5'd11, 3'd4, 3'd0, 3'd0, 1, 8'h03);
    run_instr(5'd11, 3'd5, 3'd0, 3'd0, 1, 8'h05);
    run_instr(5'd1, 3'd3, 3'd4, 3'd5, 0, 8'h00);
    tests_run++;
    if (obs_data !== 8'hFE) begin failed++; $display("FAIL sub_result got %h want fe", obs_data); end
    tests_run++;
    if ({flag_z, flag_n, flag_c} !== 3'b011) begin failed++; $display("FAIL sub_flags got %b want 011", {flag_z, flag_n, flag_c}); end
    run_instr(5'd3, 3'd6, 3'd4, 3'd5, 0, 8'h00);
    tests_run++;
    if (obs_data !== 8'h07) begin failed++; $display("FAIL or_result got %h want 07", obs_data); end
    tests_run++;
    if ({flag_z, flag_n, flag_c} !== 3'b001) begin failed++; $display("FAIL or_keeps_c got %b want 001", {flag_z, flag_n, flag_c}); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops [3];
    logic [2:0] rds [3];
    logic [7:0] imms [3];
    logic [7:0] expq [$];
    int acc_cyc [$];
    int idx = -1, wbs = 0;
    logic adv = 1;
    ops = '{5'd11, 5'd0, 5'd1};
    rds = '{3'd1, 3'd2, 3'd3};
    imms = '{8'h90, 8'h80, 8'h11};
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (adv) begin
        idx++; adv = 0;
        instr_valid = idx < 3;
        if (idx < 3) begin
          instr_op = ops[idx]; instr_rd = rds[idx]; instr_rs1 = idx == 0 ? 3'd0 : rds[idx-1];
          instr_use_imm = 1; instr_imm = imms[idx];
        end
      end
      if (wb_valid) begin
        wbs++;
        tests_run++;
        if (expq.size() == 0) begin failed++; $display("FAIL b2b_extra_wb data %h", wb_data); end
        else if (wb_data !== expq[0]) begin failed++; $display("FAIL b2b_data got %h want %h", wb_data, expq[0]); end
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (instr_ready && instr_valid) begin
        acc_cyc.push_back(cyc);
        model_step(instr_op, instr_rd, instr_rs1, 3'd0, 1, instr_imm);
        expq.push_back(exp_res);
        adv = 1;
      end
    end
    tests_run++;
    if (wbs != 3) begin failed++; $display("FAIL b2b_wb_count got %0d want 3", wbs); end
    tests_run++;
    if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 4 || acc_cyc[2] - acc_cyc[1] != 4) begin
      failed++; $display("FAIL b2b_accept_spacing got %0d accepts", acc_cyc.size());
    end
    tests_run++;
    if ({flag_z, flag_n, flag_c} !== {m_z, m_n, m_c}) begin failed++; $display("FAIL b2b_flags got %b want %b", {flag_z, flag_n, flag_c}, {m_z, m_n, m_c}); end
  endtask

  task automatic test_r0_and_abort();
    int wbs = 0;
    run_instr(5'd11, 3'd0, 3'd0, 3'd0, 1, 8'h77);
    tests_run++;
    if ({wbv_pat[3], obs_rd, obs_data} !== {1'b1, 3'd0, 8'h77}) begin failed++; $display("FAIL r0_wb got %b %0d %h want 1 0 77", wbv_pat[3], obs_rd, obs_data); end
    dbg_raddr = 3'd0; #1;
    tests_run++;
    if (dbg_rdata !== 8'h00) begin failed++; $display("FAIL r0_stays_zero got %h want 00", dbg_rdata); end
    tests_run++;
    if (flag_z !== 1'b0) begin failed++; $display("FAIL r0_flag_z got %b want 0", flag_z); end
    @(negedge clk);
    instr_op = 5'd11; instr_rd = 3'd7; instr_use_imm = 1; instr_imm = 8'h42; instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    tests_run++;
    if (alu_enable !== 1'b1) begin failed++; $display("FAIL abort_in_fire enable got %b want 1", alu_enable); end
    reset = 1; #1;
    model_reset();
    tests_run++;
    if ({alu_enable, instr_ready, wb_valid} !== 3'b010) begin failed++; $display("FAIL abort_ctl got %b want 010", {alu_enable, instr_ready, wb_valid}); end
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (wb_valid) wbs++; end
    tests_run++;
    if (wbs != 0) begin failed++; $display("FAIL abort_no_wb got %0d pulses want 0", wbs); end
    dbg_raddr = 3'd7; #1;
    tests_run++;
    if (dbg_rdata !== mreg[7]) begin failed++; $display("FAIL abort_r7 got %h want %h", dbg_rdata, mreg[7]); end
  endtask

  task automatic test_random();
    logic [4:0] op_set [7];
    logic [4:0] op;
    logic [2:0] rd;
    op_set = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd11, 5'd7};
    for (int n = 0; n < 40; n++) begin
      op = op_set[$urandom_range(0, 6)];
      rd = 3'($urandom_range(0, 7));
      run_instr(op, rd, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom));
      tests_run++;
      if ({wbv_pat, en_pat, obs_rd, obs_data} !== {4'b1000, 4'b0010, rd, exp_res}) begin
        failed++; $display("FAIL rand_%0d op%0d got wbv%b en%b rd%0d %h want wbv1000 en0010 rd%0d %h", n, op, wbv_pat, en_pat, obs_rd, obs_data, rd, exp_res);
      end
      tests_run++;
      if ({flag_z, flag_n, flag_c} !== {m_z, m_n, m_c}) begin failed++; $display("FAIL rand_flags_%0d got %b want %b", n, {flag_z, flag_n, flag_c}, {m_z, m_n, m_c}); end
      dbg_raddr = 3'($urandom_range(0, 7)); #1;
      tests_run++;
      if (dbg_rdata !== mreg[dbg_raddr]) begin failed++; $display("FAIL rand_rf_%0d r%0d got %h want %h", n, dbg_raddr, dbg_rdata, mreg[dbg_raddr]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_sub_flags();
    test_back_to_back();
    test_r0_and_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
